// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants and types for the key schedule, AesBlockEnc
// and the decrypt path.
//   AES_NR / AES_NK : AES-256 round count and key length in 32-bit words
//   aes_word_t      : one 32-bit key-schedule word
//   aes_block_t     : one 128-bit state block / round key
//   AES_RCON        : round constants Rcon[1..10]
//   ks_state_e      : key-schedule sequencer states
package aes_pkg;

    localparam int AES_NR = 14;
    localparam int AES_NK = 8;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    localparam logic [7:0] AES_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic {
        KS_IDLE = 1'b0,
        KS_RUN  = 1'b1
    } ks_state_e;

    // RotWord: cyclic left rotation by one byte.
    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: SubWord, the AES S-box applied to each byte of a 32-bit word.
// Purely combinational.
//   word_i : input word
//   word_o : word with every byte substituted through the S-box
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
    end

endmodule

// File: rtl/aes_key_sched_256.sv
// aes_key_sched_256: on-the-fly AES-256 key expansion. Latches a 256-bit key
// and streams round keys rk0..rk14 over 14 consecutive slots, slot-aligned
// with AesBlockEnc's round-key inputs.
//   inClk        : clock, rising edge
//   inRstN       : asynchronous active-low reset
//   inKeyWr      : key-load strobe; accepted when idle or in the last slot
//   inKey        : cipher key, key byte 0 in [255:248]
//   outBusy      : sequence in progress (slots 0..13)
//   outKeyValid  : outKeyData0 holds a valid round key
//   outStart     : pulse in slot 0
//   outLast      : pulse in slot 13
//   outRound     : current slot index, 0 when idle
//   outKeyData0  : rk[n] in slot n, 0 when idle
//   outKeyData1  : rk[n+1] in slots 12 and 13, 0 otherwise
module aes_key_sched_256
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int SLOTS = NR
) (
    input  logic                  inClk,
    input  logic                  inRstN,
    input  logic                  inKeyWr,
    input  logic [AES_NK*32-1:0]  inKey,
    output logic                  outBusy,
    output logic                  outKeyValid,
    output logic                  outStart,
    output logic                  outLast,
    output logic [3:0]            outRound,
    output logic [127:0]          outKeyData0,
    output logic [127:0]          outKeyData1
);

    if (NR != AES_NR || SLOTS != NR) begin : g_bad_cfg
        $error("aes_key_sched_256 supports AES-256 only (NR = 14, SLOTS = NR)");
    end

    localparam logic [3:0] LAST_SLOT = 4'(SLOTS - 1);
    localparam logic [3:0] KEY1_SLOT = 4'(SLOTS - 2);

    ks_state_e      state_q;
    logic [3:0]     cnt_q;
    logic [255:0]   win_q;      // {rk[n], rk[n+1]}
    logic [7:0]     rcon_q;
    logic           start_q;
    logic           last_q;
    logic           key1_q;     // second round-key output is live (slots 12, 13)

    logic           accept;
    logic           even_step;
    aes_word_t      t_word;
    aes_word_t      sub_in;
    aes_word_t      sub_out;
    aes_word_t      t_prime;
    aes_word_t      w0_new, w1_new, w2_new, w3_new;
    aes_block_t     rk_new;

    // A reload in the last slot chains straight into slot 0 of the new key.
    assign accept = inKeyWr && (state_q == KS_IDLE || last_q);

    // In slot n the block being built is rk[n+2], which has the parity of n.
    assign even_step = ~cnt_q[0];
    assign t_word    = win_q[31:0];
    assign sub_in    = even_step ? rot_word(t_word) : t_word;

    aes_sub_word u_sub_word (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    assign t_prime = sub_out ^ (even_step ? {rcon_q, 24'h0} : 32'h0);

    // Each new word folds in the same word of the block eight words back.
    assign w0_new = win_q[255:224] ^ t_prime;
    assign w1_new = win_q[223:192] ^ w0_new;
    assign w2_new = win_q[191:160] ^ w1_new;
    assign w3_new = win_q[159:128] ^ w2_new;
    assign rk_new = {w0_new, w1_new, w2_new, w3_new};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state_q <= KS_IDLE;
            cnt_q   <= '0;
            // NOTE: the wide window is reset like any control register so no
            // key material survives a reset.
            win_q   <= '0;
            rcon_q  <= '0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
            key1_q  <= 1'b0;
        end else if (accept) begin
            state_q <= KS_RUN;
            cnt_q   <= '0;
            win_q   <= inKey;
            rcon_q  <= AES_RCON[1];
            start_q <= 1'b1;
            last_q  <= 1'b0;
            key1_q  <= 1'b0;
        end else if (state_q == KS_RUN) begin
            start_q <= 1'b0;
            if (last_q) begin
                // End of sequence: scrub the key material on the way to idle.
                state_q <= KS_IDLE;
                cnt_q   <= '0;
                win_q   <= '0;
                rcon_q  <= '0;
                last_q  <= 1'b0;
                key1_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_q + 4'd1;
                win_q  <= {win_q[127:0], rk_new};
                if (even_step) begin
                    rcon_q <= {rcon_q[6:0], 1'b0};
                end
                last_q <= (cnt_q == LAST_SLOT - 4'd1);
                key1_q <= (cnt_q >= KEY1_SLOT - 4'd1);
            end
        end
    end

    assign outBusy     = (state_q == KS_RUN);
    assign outKeyValid = (state_q == KS_RUN);
    assign outStart    = start_q;
    assign outLast     = last_q;
    assign outRound    = cnt_q;
    assign outKeyData0 = (state_q == KS_RUN) ? win_q[255:128] : 128'h0;
    assign outKeyData1 = key1_q ? win_q[127:0] : 128'h0;

endmodule

// File: tb/tb_aes_key_sched_256.sv
module tb_aes_key_sched_256;

    typedef logic [127:0] rk_arr_t [15];
    typedef struct packed {
        logic [3:0]   round;
        logic [127:0] d0;
        logic [127:0] d1;
        logic         start;
        logic         last;
    } exp_t;

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_B  =
        256'hdeadbeef00000000cafef00d11111111feedface22222222badc0ffe33333333;
    localparam logic [255:0] KEY_4  =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_5  =
        256'hfedcba9876543210f0e1d2c3b4a5968778695a4b3c2d1e0f0123456789abcdef;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_wr = 1'b0;
    logic [255:0] key = '0;
    logic         busy, valid, start, last;
    logic [3:0]   round;
    logic [127:0] d0, d1;

    exp_t         exp_q[$];
    int           n_vec = 0;
    int           n_bad = 0;
    int           m_slot = -1;     // slot the bench expects on the outputs
    int           n_starts = 0;
    logic [127:0] cap_d0 [16];
    logic [127:0] cap_d1 [16];
    logic [7:0]   sbox_m [256];

    aes_key_sched_256 dut (
        .inClk       (clk),
        .inRstN      (rst_n),
        .inKeyWr     (key_wr),
        .inKey       (key),
        .outBusy     (busy),
        .outKeyValid (valid),
        .outStart    (start),
        .outLast     (last),
        .outRound    (round),
        .outKeyData0 (d0),
        .outKeyData1 (d1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: FIPS-197 word-by-word expansion with an S-box derived
    // from the GF(2^8) inverse and the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] k, output rk_arr_t rk);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            temp = w[i-1];
            if (i % 8 == 0) begin
                temp = sub_word_m({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                temp = sub_word_m(temp);
            end
            w[i] = w[i-8] ^ temp;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic push_seq(input logic [255:0] k);
        rk_arr_t rk;
        exp_t    e;
        expand(k, rk);
        for (int n = 0; n < 14; n++) begin
            e.round = 4'(n);
            e.d0    = rk[n];
            e.d1    = (n >= 12) ? rk[n+1] : 128'h0;
            e.start = (n == 0);
            e.last  = (n == 13);
            exp_q.push_back(e);
        end
    endtask

    // One clock: at the edge, apply the accept rule to the bench's inputs and
    // queue the expected slots; return at the falling edge for new stimulus.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            m_slot = -1;
        end else if (key_wr && (m_slot < 0 || m_slot == 13)) begin
            push_seq(key);
            m_slot = 0;
        end else if (m_slot >= 0) begin
            m_slot = (m_slot == 13) ? -1 : m_slot + 1;
        end
        @(negedge clk);
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clear_cap();
        for (int s = 0; s < 16; s++) begin
            cap_d0[s] = '1;
            cap_d1[s] = '1;
        end
    endtask

    // Monitor: pops one expected slot whenever the DUT presents a valid key.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (valid) begin
                check("slot_timing", 256'(round), (m_slot < 0) ? 256'h10 : 256'(m_slot));
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 256'd1, 256'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("round", 256'(round), 256'(e.round));
                    check("key_data0", 256'(d0), 256'(e.d0));
                    check("key_data1", 256'(d1), 256'(e.d1));
                    check("flags", 256'({busy, start, last}), 256'({1'b1, e.start, e.last}));
                    cap_d0[round] = d0;
                    cap_d1[round] = d1;
                    if (start) n_starts++;
                end
            end else begin
                check("idle_flags", 256'({busy, start, last, round}), 256'd0);
                check("idle_data", {d0, d1}, 256'd0);
                check("idle_expected", 256'(m_slot >= 0), 256'd0);
            end
        end
    end

    initial begin
        logic [127:0] acc;
        build_sbox();
        clear_cap();
        repeat (3) step();
        rst_n = 1'b1;

        // FIPS-197 C.3 key, single load pulse
        key = KEY_C3; key_wr = 1'b1;
        step();
        key_wr = 1'b0; key = '0;
        repeat (16) step();
        check("c3_rk0",  256'(cap_d0[0]),  256'(128'h000102030405060708090a0b0c0d0e0f));
        check("c3_rk1",  256'(cap_d0[1]),  256'(128'h101112131415161718191a1b1c1d1e1f));
        check("c3_rk2",  256'(cap_d0[2]),  256'(128'ha573c29fa176c498a97fce93a572c09c));
        check("c3_rk3",  256'(cap_d0[3]),  256'(128'h1651a8cd0244beda1a5da4c10640bade));
        check("c3_s12_k0", 256'(cap_d0[12]), 256'(128'h2541fe719bf500258813bbd55a721c0a));
        check("c3_s12_k1", 256'(cap_d1[12]), 256'(128'h4e5a6699a9f24fe07e572baacdf8cdea));
        check("c3_s13_k0", 256'(cap_d0[13]), 256'(128'h4e5a6699a9f24fe07e572baacdf8cdea));
        check("c3_s13_k1", 256'(cap_d1[13]), 256'(128'h24fc79ccbf0979e9371ac23c6d68de36));

        // All-zero key
        clear_cap();
        key = '0; key_wr = 1'b1;
        step();
        key_wr = 1'b0;
        repeat (16) step();
        check("zero_rk2", 256'(cap_d0[2]), 256'({4{32'h62636363}}));
        check("zero_rk3", 256'(cap_d0[3]), 256'({4{32'haafbfbfb}}));
        acc = '0;
        for (int s = 0; s < 12; s++) acc = acc | cap_d1[s];
        check("zero_key1_early", 256'(acc), 256'd0);

        // Strobe held for 30 cycles; key disturbed only during slot 5
        clear_cap();
        n_starts = 0;
        key_wr = 1'b1;
        for (int c = 0; c < 30; c++) begin
            key = (m_slot == 5 && c < 14) ? KEY_B : KEY_C3;
            step();
        end
        key_wr = 1'b0;
        repeat (16) step();
        check("held_starts", 256'(n_starts), 256'd3);
        check("held_rk2", 256'(cap_d0[2]), 256'(128'ha573c29fa176c498a97fce93a572c09c));

        // Asynchronous reset in the middle of slot 7
        key = KEY_4; key_wr = 1'b1;
        step();
        key_wr = 1'b0;
        for (int c = 0; c < 20 && m_slot != 7; c++) step();
        check("pre_reset_round", 256'(round), 256'd7);
        #1 rst_n = 1'b0;
        #1;
        check("reset_flags", 256'({busy, valid, start, last, round}), 256'd0);
        check("reset_data", {d0, d1}, 256'd0);
        exp_q.delete();
        m_slot = -1;
        repeat (2) step();
        rst_n = 1'b1;
        clear_cap();
        key = KEY_5; key_wr = 1'b1;
        step();
        key_wr = 1'b0;
        repeat (16) step();
        check("post_reset_rk0", 256'(cap_d0[0]), 256'(KEY_5[255:128]));
        check("post_reset_rk1", 256'(cap_d0[1]), 256'(KEY_5[127:0]));

        // Random keys and random strobe pattern
        for (int c = 0; c < 300; c++) begin
            key = rand256();
            key_wr = ($urandom_range(0, 3) != 0);
            step();
        end
        key_wr = 1'b0;
        repeat (16) step();
        check("queue_drained", 256'(exp_q.size()), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
